// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory status inputs and pipeline control outputs of the pipeline controller.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 load_use;
    logic                 branch_taken;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 pc_ld;
    logic                 ifid_ld;
    logic                 idex_ld;
    logic                 exmem_ld;
    logic                 memwb_ld;
    logic                 ifid_clr;
    logic                 idex_clr;
    logic                 exmem_clr;
    logic                 memwb_clr;
    logic                 halted;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;

    // Pipeline side: reports hazards, consumes load/clear enables.
    modport master (
        output load_use, branch_taken, mem_req, mem_ready,
        input  pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld,
        input  ifid_clr, idex_clr, exmem_clr, memwb_clr,
        input  halted, stall_count, flush_count
    );

    // Controller side.
    modport slave (
        input  load_use, branch_taken, mem_req, mem_ready,
        output pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld,
        output ifid_clr, idex_clr, exmem_clr, memwb_clr,
        output halted, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stalls, flushes, memory freeze with timeout halt,
// and saturating stall/flush statistics.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus
);
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [CNT_WIDTH-1:0]   stall_q, stall_d;
    logic [CNT_WIDTH-1:0]   flush_q, flush_d;

    logic frozen;
    logic running;
    logic stall_inc;
    logic flush_inc;
    logic pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;
    logic ifid_clr, idex_clr, exmem_clr, memwb_clr;

    // State, wait counter and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Next state and the combinational load/clear enables.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        frozen    = 1'b0;
        running   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        pc_ld     = 1'b1;
        ifid_ld   = 1'b1;
        idex_ld   = 1'b1;
        exmem_ld  = 1'b1;
        memwb_ld  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        memwb_clr = 1'b0;

        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.mem_req && !bus.mem_ready) begin
                        frozen  = 1'b1;
                        state_d = ST_MEM_WAIT;
                        wait_d  = WAIT_W'(1);
                    end else begin
                        running = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!bus.mem_ready) begin
                        frozen = 1'b1;
                        if (wait_q == WAIT_W'(TIMEOUT)) begin
                            state_d = ST_HALT;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end else begin
                        running = 1'b1;
                        state_d = ST_RUN;
                        wait_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end

        // Output decode: reset > halt > freeze > flush > load-use > advance.
        if (rst) begin
            {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}  = '0;
            {ifid_clr, idex_clr, exmem_clr, memwb_clr}     = '1;
        end else if (frozen) begin
            {pc_ld, ifid_ld, idex_ld, exmem_ld} = '0;
            memwb_clr = 1'b1;
            stall_inc = 1'b1;
        end else if (running) begin
            if (bus.branch_taken) begin
                ifid_clr  = 1'b1;
                idex_clr  = 1'b1;
                flush_inc = 1'b1;
            end else if (bus.load_use) begin
                pc_ld     = 1'b0;
                ifid_ld   = 1'b0;
                idex_clr  = 1'b1;
                stall_inc = 1'b1;
            end
        end else begin
            {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld} = '0;
        end
    end

    // Saturating statistics counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
        if (flush_inc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_WIDTH'(1);
        end
    end

    assign bus.pc_ld       = pc_ld;
    assign bus.ifid_ld     = ifid_ld;
    assign bus.idex_ld     = idex_ld;
    assign bus.exmem_ld    = exmem_ld;
    assign bus.memwb_ld    = memwb_ld;
    assign bus.ifid_clr    = ifid_clr;
    assign bus.idex_clr    = idex_clr;
    assign bus.exmem_clr   = exmem_clr;
    assign bus.memwb_clr   = memwb_clr;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.stall_count = stall_q;
    assign bus.flush_count = flush_q;
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, the maximum number of MEM_WAIT cycles before the block halts (legal range 1..255).
REQ-002 Parameter: CNT_WIDTH, default 16, the width of the statistics counters.
REQ-003 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: load_use  in  1  load-use hazard detected in the ID stage.
REQ-006 Port: branch_taken  in  1  taken branch or jump resolved in the EX stage.
REQ-007 Port: mem_req  in  1  memory operation present in the MEM stage.
REQ-008 Port: mem_ready  in  1  memory completes the access this cycle.
REQ-009 Port: pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld  out  1 each  load enables for the PC and pipeline registers.
REQ-010 Port: ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  synchronous clears (bubble insert) for the pipeline registers.
REQ-011 Port: halted  out  1  block is in HALT.
REQ-012 Port: stall_count  out  CNT_WIDTH  number of stall cycles.
REQ-013 Port: flush_count  out  CNT_WIDTH  number of branch flushes.

Function
REQ-014 The FSM SHALL have three states: RUN, MEM_WAIT and HALT; the state and the wait counter are registered; ld/clr outputs are combinational from state and inputs.
REQ-015 Normal advance (RUN, no event) SHALL drive every ld=1 and every clr=0.
REQ-016 RUN with mem_req=1 and mem_ready=0 SHALL freeze: pc/ifid/idex/exmem ld=0, memwb_ld=1, memwb_clr=1 (bubble into WB), all other clr=0; next state is MEM_WAIT; wait counter is loaded with 1.
REQ-017 RUN with mem_req=1 and mem_ready=1 SHALL NOT stall.
REQ-018 MEM_WAIT with mem_ready=0 SHALL apply the REQ-016 freeze outputs and increment the wait counter; load_use and branch_taken are ignored.
REQ-019 MEM_WAIT with mem_ready=1 SHALL produce the RUN outputs for the current load_use/branch_taken (REQ-015/020/021) in the same cycle, with next state RUN.
REQ-020 Branch flush (not frozen, branch_taken=1) SHALL drive pc_ld=1, ifid_clr=1, idex_clr=1, all other ld=1, other clr=0; flush_count increments.
REQ-021 Load-use stall (not frozen, load_use=1, branch_taken=0) SHALL drive pc_ld=0, ifid_ld=0, idex_clr=1, other ld=1, other clr=0; stall_count increments.
REQ-022 Priority SHALL be: HALT > memory freeze > branch flush > load-use > advance; branch_taken with load_use flushes only (no stall_count increment).
REQ-023 A memory freeze SHALL increment stall_count once per frozen cycle, including the entry cycle.
REQ-024 If the wait counter equals TIMEOUT while in MEM_WAIT and mem_ready=0, next state SHALL be HALT.
REQ-025 HALT SHALL drive every ld=0 and every clr=0, with halted=1; it is left only by rst.
REQ-026 Counters SHALL saturate at all-ones and never wrap.

Reset
REQ-027 While rst=1, every ld SHALL be 0 and every clr SHALL be 1, overriding all inputs.
REQ-028 After rst, state SHALL be RUN, the wait counter 0, stall_count=0, flush_count=0 and halted=0.
REQ-029 rst asserted in MEM_WAIT or HALT SHALL return the block to RUN on the next edge, discarding the wait in progress.

Verification
REQ-030 After reset, idle inputs for 3 cycles -> all ld=1, clr=0, counts 0.
REQ-031 load_use=1 for 1 cycle -> that cycle pc_ld=0, ifid_ld=0, idex_clr=1; stall_count=1.
REQ-032 load_use=1 and branch_taken=1 together -> ifid_clr=1, idex_clr=1, pc_ld=1; flush_count=1, stall_count=0.
REQ-033 mem_req=1 with mem_ready low for 4 cycles then high -> 4 frozen cycles with memwb_clr=1, advance in the 5th cycle; stall_count=4; branch_taken pulsed while frozen is ignored.
REQ-034 TIMEOUT=3, mem_req=1 with mem_ready held low -> halted=1 after the 3rd wait cycle, all ld/clr=0; rst then gives RUN with counts 0.
REQ-035 Saturation with CNT_WIDTH=4: 20 load-use cycles -> stall_count=15.
